alu_seq: RTL and testbench

- Parametrised, handshaked successor of the team's 4-bit combinational ALU.
- Operands are WIDTH bits wide, and the opcode map keeps the existing 16-entry encoding.
- Multiply and divide run as iterative multi-cycle operations. All other ops complete in one cycle.
- Results are registered and presented with valid/ready flow control and status flags. The block sits between an operand-issue stage and a result consumer.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 81 ++++++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ==== alu_pkg : opcode map and FSM state encoding shared by the alu_seq block ====
// Rev 1.0 - initial release
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_EQ   = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_NOR  = 4'hD;
    localparam logic [3:0] OP_XNOR = 4'hE;
    localparam logic [3:0] OP_GT   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ==== alu_muldiv_iter : iterative shift-add multiplier / restoring divider, one step per cycle ====
// Rev 1.0 - initial release
`default_nettype none

module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_or_qr
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_is_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend->quotient}.
    // The remainder stays below b, so the trial difference's top bit is a clean borrow.
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shifted = {r_hi, r_lo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, r_b};
        w_ge      = ~w_trial[WIDTH];
        if (r_is_div) begin
            w_hi_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // done flags the final step; prod_or_qr is that step's outcome, captured by the parent.
    assign done       = r_busy && (r_cnt == CW'(WIDTH-1));
    assign prod_or_qr = {w_hi_nxt, w_lo_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_is_div <= is_div;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= a;
            r_b      <= b;
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ==== alu_seq : handshaked ALU, single-cycle ops plus iterative mul/div, registered result+flags ====
// Rev 1.0 - initial release
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_dbz
);

    localparam int SHW = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_dbz;

    logic               w_start;
    logic               w_load;
    logic [2*WIDTH-1:0] w_load_res;
    logic               w_load_carry;
    logic               w_load_dbz;
    logic               w_md_done;
    logic [2*WIDTH-1:0] w_md_res;

    logic [2*WIDTH-1:0] w_sc_res;
    logic               w_sc_carry;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [2*WIDTH-1:0] w_shl;
    logic [WIDTH-1:0]   w_shr;
    logic [SHW-2:0]     w_rot;
    logic [SHW-1:0]     w_rot_c;
    logic [WIDTH-1:0]   w_rol;
    logic [WIDTH-1:0]   w_ror;
    logic               w_big_l;
    logic               w_big_r;
    logic               w_is_muldiv;
    logic               w_div_zero;

    assign w_add   = {1'b0, a} + {1'b0, b};
    assign w_sub   = {1'b0, a} - {1'b0, b};
    assign w_shl   = {{WIDTH{1'b0}}, a} << b[SHW-1:0];
    assign w_shr   = a >> b[SHW-2:0];
    assign w_rot   = b[SHW-2:0];
    assign w_rot_c = SHW'(WIDTH) - {1'b0, w_rot};
    assign w_rol   = (a << w_rot) | (a >> w_rot_c);
    assign w_ror   = (a >> w_rot) | (a << w_rot_c);
    assign w_big_l = {1'b0, b} >= (WIDTH+1)'(2*WIDTH);
    assign w_big_r = {1'b0, b} >= (WIDTH+1)'(WIDTH);

    assign w_is_muldiv = (sel == OP_MUL) || (sel == OP_DIV);
    assign w_div_zero  = (sel == OP_DIV) && (b == '0);

    always_comb begin
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        case (sel)
            OP_ADD: begin
                w_sc_res   = {{(WIDTH-1){1'b0}}, w_add};
                w_sc_carry = w_add[WIDTH];
            end
            OP_SUB: begin
                w_sc_res   = {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
                w_sc_carry = w_sub[WIDTH];
            end
            OP_SHL:  w_sc_res = w_big_l ? '0 : w_shl;
            OP_SHR:  w_sc_res = {{WIDTH{1'b0}}, (w_big_r ? {WIDTH{1'b0}} : w_shr)};
            OP_ROL:  w_sc_res = {{WIDTH{1'b0}}, w_rol};
            OP_ROR:  w_sc_res = {{WIDTH{1'b0}}, w_ror};
            OP_AND:  w_sc_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   w_sc_res = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  w_sc_res = {{WIDTH{1'b0}}, a ^ b};
            OP_EQ:   w_sc_res = {{(2*WIDTH-1){1'b0}}, (a == b)};
            OP_NAND: w_sc_res = {{WIDTH{1'b0}}, ~(a & b)};
            OP_NOR:  w_sc_res = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XNOR: w_sc_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_GT:   w_sc_res = {{(2*WIDTH-1){1'b0}}, (a > b)};
            default: w_sc_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_load_res   = w_sc_res;
        w_load_carry = w_sc_carry;
        w_load_dbz   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_div_zero) begin
                        w_load       = 1'b1;
                        w_load_res   = {a, {WIDTH{1'b1}}};
                        w_load_carry = 1'b0;
                        w_load_dbz   = 1'b1;
                        w_state_nxt  = DONE;
                    end else if (w_is_muldiv) begin
                        w_start     = 1'b1;
                        w_state_nxt = EXEC;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            EXEC: begin
                if (w_md_done) begin
                    w_load       = 1'b1;
                    w_load_res   = w_md_res;
                    w_load_carry = 1'b0;
                    w_state_nxt  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_result <= w_load_res;
                r_zero   <= (w_load_res == '0);
                r_carry  <= w_load_carry;
                r_dbz    <= w_load_dbz;
            end
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_start),
        .is_div     (sel == OP_DIV),
        .a          (a),
        .b          (b),
        .done       (w_md_done),
        .prod_or_qr (w_md_res)
    );

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_dbz   = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ==== tb_alu_seq : directed self-checking bench for alu_seq (WIDTH=8) ====
// Rev 1.0 - initial release
`default_nettype none

module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_dbz;
    logic [2:0]  fl;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t tbl [24];

    assign fl = {flag_zero, flag_carry, flag_dbz};

    alu_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_dbz   (flag_dbz)
    );

    always #5 clk = ~clk;

    // Presents one op for a single accepting edge, then scrambles the operands.
    task automatic issue(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        sel = s; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~x; b = ~y; sel = ~s;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 16'h0000 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b result=%h flags=%b, required 0/0000/000", out_valid, result, fl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_cycle();
        int lat;
        tbl[0]  = '{4'h0, 8'hFF, 8'h01, 16'h0100, 3'b010};
        tbl[1]  = '{4'h0, 8'h00, 8'h00, 16'h0000, 3'b100};
        tbl[2]  = '{4'h1, 8'h03, 8'h05, 16'h00FE, 3'b010};
        tbl[3]  = '{4'h1, 8'h05, 8'h03, 16'h0002, 3'b000};
        tbl[4]  = '{4'h4, 8'h81, 8'h09, 16'h0200, 3'b000};
        tbl[5]  = '{4'h4, 8'h81, 8'h01, 16'h0102, 3'b000};
        tbl[6]  = '{4'h4, 8'h81, 8'h10, 16'h0000, 3'b100};
        tbl[7]  = '{4'h4, 8'h81, 8'h0F, 16'h8000, 3'b000};
        tbl[8]  = '{4'h5, 8'h81, 8'h03, 16'h0010, 3'b000};
        tbl[9]  = '{4'h5, 8'h81, 8'h08, 16'h0000, 3'b100};
        tbl[10] = '{4'h6, 8'h81, 8'h01, 16'h0003, 3'b000};
        tbl[11] = '{4'h6, 8'h81, 8'h09, 16'h0003, 3'b000};
        tbl[12] = '{4'h7, 8'h81, 8'h01, 16'h00C0, 3'b000};
        tbl[13] = '{4'h8, 8'hF0, 8'h3C, 16'h0030, 3'b000};
        tbl[14] = '{4'h9, 8'hF0, 8'h3C, 16'h00FC, 3'b000};
        tbl[15] = '{4'hA, 8'hF0, 8'h3C, 16'h00CC, 3'b000};
        tbl[16] = '{4'hC, 8'hF0, 8'hFF, 16'h000F, 3'b000};
        tbl[17] = '{4'hD, 8'h00, 8'h0F, 16'h00F0, 3'b000};
        tbl[18] = '{4'hE, 8'hF0, 8'hFF, 16'h00F0, 3'b000};
        tbl[19] = '{4'hB, 8'h5A, 8'h5A, 16'h0001, 3'b000};
        tbl[20] = '{4'hB, 8'h5A, 8'h5B, 16'h0000, 3'b100};
        tbl[21] = '{4'hF, 8'h05, 8'h09, 16'h0000, 3'b100};
        tbl[22] = '{4'hF, 8'h09, 8'h05, 16'h0001, 3'b000};
        tbl[23] = '{4'h7, 8'h01, 8'h08, 16'h0001, 3'b000};
        for (int i = 0; i < 24; i++) begin
            issue(tbl[i].op, tbl[i].x, tbl[i].y);
            wait_valid(lat);
            n_cmp++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL sc_latency[%0d]: got %0d cycles, required 1", i, lat);
            end
            n_cmp++;
            if (result !== tbl[i].r || fl !== tbl[i].f) begin
                n_fail++;
                $display("FAIL sc_op[%0d] sel=%h a=%h b=%h: result=%h flags=%b, required %h/%b",
                         i, tbl[i].op, tbl[i].x, tbl[i].y, result, fl, tbl[i].r, tbl[i].f);
            end
            retire();
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        issue(4'h2, 8'h0F, 8'h0F);
        retire();
        retire();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_op: out_valid=%b result=%h, required 0/0000", out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: in_ready=%b, required 1", in_ready);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid === 1'b1) seen++;
            retire();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_stale: out_valid high %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_mul();
        int lat;
        int bad_ready;
        issue(4'h2, 8'hC8, 8'hC8);
        lat = 1;
        bad_ready = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) bad_ready++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready !== 1'b0) bad_ready++;
        n_cmp++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d cycles, required 9", lat);
        end
        n_cmp++;
        if (bad_ready !== 0) begin
            n_fail++;
            $display("FAIL mul_in_ready: in_ready high %0d cycles while busy, required 0", bad_ready);
        end
        n_cmp++;
        if (result !== 16'h9C40 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL mul_c8xc8: result=%h flags=%b, required 9c40/000", result, fl);
        end
        retire();
        issue(4'h2, 8'hFF, 8'hFF);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 9 || result !== 16'hFE01 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL mul_ffxff: lat=%0d result=%h flags=%b, required 9/fe01/000", lat, result, fl);
        end
        retire();
    endtask

    task automatic test_div();
        int lat;
        issue(4'h3, 8'hC8, 8'h07);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 9 || result !== 16'h041C || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL div_c8_07: lat=%0d result=%h flags=%b, required 9/041c/000", lat, result, fl);
        end
        retire();
        issue(4'h3, 8'h05, 8'h09);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 9 || result !== 16'h0500 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL div_05_09: lat=%0d result=%h flags=%b, required 9/0500/000", lat, result, fl);
        end
        retire();
        issue(4'h3, 8'h2A, 8'h00);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 1 || result !== 16'h2AFF || fl !== 3'b001) begin
            n_fail++;
            $display("FAIL div_by_zero: lat=%0d result=%h flags=%b, required 1/2aff/001", lat, result, fl);
        end
        retire();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        issue(4'h0, 8'h12, 8'h34);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 1 || result !== 16'h0046) begin
            n_fail++;
            $display("FAIL bp_first: lat=%0d result=%h, required 1/0046", lat, result);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || result !== 16'h0046 || fl !== 3'b000 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h flags=%b in_ready=%b, required 1/0046/000/0",
                         k, out_valid, result, fl, in_ready);
            end
            if (k == 1) begin
                @(negedge clk);
                sel = 4'h0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        retire();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        retire();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_pulse: out_valid=%b result=%h, required 0", out_valid, result);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sel       = '0;
        test_reset();
        test_single_cycle();
        test_reset_mid_op();
        test_mul();
        test_div();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
